// File: rtl/spin_update_ctrl.sv
// spin_update_ctrl: sweeps the spin vector against fields from the loop block.
// Each sweep requests fields (readySignal), waits LATENCY cycles, captures all N
// fields at once, then updates one spin per cycle against a thermal threshold
// taken from a 16-bit Galois LFSR.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start; busy low
// S_KICK   | one-cycle readySignal request; load the settle counter
// S_WAIT   | settle counter running; capture fields when it reaches 0
// S_UPDATE | one spin per cycle, idx 0..N-1; LFSR steps every cycle
// S_DONE   | one-cycle done pulse, back to IDLE
module spin_update_ctrl #(
  parameter int          N          = 4,
  parameter int          DATABITS   = 16,
  parameter int          LATENCY    = 4,
  parameter int          TEMP_SHIFT = 0,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter logic [N-1:0] SPIN_INIT = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            num_sweeps,
  input  logic [DATABITS*N-1:0] matrix_output,
  output logic                  readySignal,
  output logic [N-1:0]          spins,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            sweep_count
);

  localparam int              IDXW      = (N > 1) ? $clog2(N) : 1;
  localparam int              CNTW      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [15:0]     SEED_EFF  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0]     LFSR_MASK = 16'hB400;
  localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(N - 1);
  localparam logic [CNTW-1:0] WAIT_LOAD = CNTW'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KICK   = 3'd1,
    S_WAIT   = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNTW-1:0]         r_wait_cnt;
  logic [IDXW-1:0]         r_idx;
  logic [7:0]              r_num_sweeps;
  logic [7:0]              r_sweep_cnt;
  logic [DATABITS*N-1:0]   r_field_buf;
  logic [N-1:0]            r_spins;
  logic [15:0]             r_lfsr;

  logic                    w_accept;
  logic                    w_capture;
  logic                    w_last_upd;
  logic                    w_updating;
  logic [15:0]             w_lfsr_nxt;
  logic signed [DATABITS-1:0] w_field;
  logic signed [DATABITS-1:0] w_thr;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_updating = (r_state == S_UPDATE);
  assign w_field    = r_field_buf[r_idx*DATABITS +: DATABITS];
  assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);

  // A shift at or beyond the field width means zero temperature: threshold is 0.
  if (TEMP_SHIFT >= DATABITS) begin : g_zero_temp
    assign w_thr = '0;
  end else begin : g_heat_bath
    assign w_thr = $signed(r_lfsr[DATABITS-1:0]) >>> TEMP_SHIFT;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    readySignal = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    w_capture   = 1'b0;
    w_last_upd  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = (num_sweeps != 8'd0) ? S_KICK : S_DONE;
        end
      end
      S_KICK: begin
        readySignal = 1'b1;
        busy        = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (r_wait_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_UPDATE;
        end
      end
      S_UPDATE: begin
        busy = 1'b1;
        if (r_idx == IDX_LAST) begin
          w_last_upd  = 1'b1;
          w_state_nxt = ((r_sweep_cnt + 8'd1) == r_num_sweeps) ? S_DONE : S_KICK;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Run bookkeeping: sweep target latched on accept, completed sweeps counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_sweeps <= 8'd0;
      r_sweep_cnt  <= 8'd0;
    end else if (w_accept) begin
      r_num_sweeps <= num_sweeps;
      r_sweep_cnt  <= 8'd0;
    end else if (w_last_upd) begin
      r_sweep_cnt <= r_sweep_cnt + 8'd1;
    end
  end

  // Settle down-counter, field capture and spin index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt  <= '0;
      r_field_buf <= '0;
      r_idx       <= '0;
    end else begin
      if (r_state == S_KICK) begin
        r_wait_cnt <= WAIT_LOAD;
      end else if ((r_state == S_WAIT) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - 1'b1;
      end
      if (w_capture) begin
        r_field_buf <= matrix_output;
        r_idx       <= '0;
      end else if (w_updating) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Spin update against the threshold; ties keep the current spin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spins <= SPIN_INIT;
      r_lfsr  <= SEED_EFF;
    end else if (w_updating) begin
      r_lfsr <= w_lfsr_nxt;
      if (w_field > w_thr) begin
        r_spins[r_idx] <= 1'b1;
      end else if (w_field < w_thr) begin
        r_spins[r_idx] <= 1'b0;
      end
    end
  end

  assign spins       = r_spins;
  assign sweep_count = r_sweep_cnt;

endmodule

// File: tb/tb_spin_update_ctrl.sv
// Bench for spin_update_ctrl: zero-temperature table runs, start/reset corner
// sequences, and a randomized stochastic run against a timeline reference model.
module tb_spin_update_ctrl;

  localparam int N      = 4;
  localparam int LAT    = 4;
  localparam int PERIOD = 1 + LAT + N;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        a_start, b_start;
  logic [7:0]  a_ns, b_ns;
  logic [63:0] a_mo, b_mo;
  logic        a_ready, b_ready, a_busy, b_busy, a_done, b_done;
  logic [3:0]  a_spins, b_spins;
  logic [7:0]  a_sc, b_sc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spin_update_ctrl #(
    .N(4), .DATABITS(16), .LATENCY(4), .TEMP_SHIFT(16),
    .LFSR_SEED(16'hACE1), .SPIN_INIT(4'b0101)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .num_sweeps(a_ns),
    .matrix_output(a_mo), .readySignal(a_ready), .spins(a_spins),
    .busy(a_busy), .done(a_done), .sweep_count(a_sc)
  );

  spin_update_ctrl #(
    .N(4), .DATABITS(16), .LATENCY(4), .TEMP_SHIFT(0),
    .LFSR_SEED(16'hACE1), .SPIN_INIT(4'b0000)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .num_sweeps(b_ns),
    .matrix_output(b_mo), .readySignal(b_ready), .spins(b_spins),
    .busy(b_busy), .done(b_done), .sweep_count(b_sc)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] fields;
    logic [7:0]  ns;
    logic [3:0]  exp_spins;
  } vec_t;

  vec_t vecs[5];

  // One run on dut_a with fixed fields; timing, pulses, busy and final spins.
  task automatic run_vec(input vec_t v, input int id);
    int pulses   = 0;
    int last     = -100;
    int done_k   = -1;
    int gap_bad  = 0;
    int busy_bad = 0;
    int exp_done = int'(v.ns) * PERIOD + 1;
    @(negedge clk);
    a_mo    = v.fields;
    a_ns    = v.ns;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    for (int k = 1; k <= exp_done + 20; k++) begin
      if (a_ready) begin
        if (pulses > 0 && (k - last) != PERIOD) gap_bad++;
        pulses++;
        last = k;
      end
      if (a_busy !== (k < exp_done)) busy_bad++;
      if (a_done) begin
        done_k = k;
        break;
      end
      @(posedge clk); #1;
    end
    check($sformatf("v%0d_done_cycle", id), done_k, exp_done);
    check($sformatf("v%0d_ready_pulses", id), pulses, int'(v.ns));
    check($sformatf("v%0d_ready_spacing", id), gap_bad, 0);
    check($sformatf("v%0d_busy", id), busy_bad, 0);
    check($sformatf("v%0d_spins", id), a_spins, v.exp_spins);
    check($sformatf("v%0d_sweep_count", id), a_sc, v.ns);
  endtask

  // Starts inside a run are ignored; a start held through DONE launches one run.
  task automatic seq_start_during_run();
    int rdy_k[$];
    int done_k[$];
    @(negedge clk);
    a_mo    = 64'hFFFF_FFFF_FFFF_FFFF;
    a_ns    = 8'd2;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    a_ns    = 8'd1;
    for (int k = 1; k <= 45; k++) begin
      if (a_ready) rdy_k.push_back(k);
      if (a_done)  done_k.push_back(k);
      a_start = (k == 3) || (k == 7) || (k >= 17 && k <= 20);
      @(posedge clk); #1;
    end
    a_start = 1'b0;
    check("t4_ready_count", rdy_k.size(), 3);
    check("t4_done_count", done_k.size(), 2);
    if (rdy_k.size() == 3) check("t4_relaunch_ready", rdy_k[2], 21);
    if (done_k.size() == 2) begin
      check("t4_first_done", done_k[0], 19);
      check("t4_second_done", done_k[1], 30);
    end
    check("t4_spins", a_spins, 4'b0000);
    check("t4_sweep_count", a_sc, 8'd1);
  endtask

  // Asynchronous reset in the middle of UPDATE.
  task automatic seq_async_reset();
    int done_seen = 0;
    @(negedge clk);
    a_mo    = {4{16'h0064}};
    a_ns    = 8'd1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); #1;
    end
    check("t5_spins_before_reset", a_spins, 4'b0011);
    check("t5_busy_before_reset", a_busy, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_spins_async", a_spins, 4'b0101);
    check("t5_busy_async", a_busy, 1'b0);
    check("t5_done_async", a_done, 1'b0);
    check("t5_ready_async", a_ready, 1'b0);
    check("t5_sweep_async", a_sc, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (a_done || a_busy) done_seen++;
    end
    check("t5_no_done_after_reset", done_seen, 0);
    check("t5_spins_held", a_spins, 4'b0101);
  endtask

  // Stochastic run on dut_b against a reference that follows the sweep timeline.
  task automatic seq_stochastic();
    logic [15:0] m_lfsr  = 16'hACE1;
    logic [3:0]  m_spins = 4'b0000;
    logic [63:0] m_buf   = '0;
    logic [63:0] prev;
    int          total   = 20 * PERIOD;
    int          done_k  = -1;
    int          s, p, i;
    shortint     h, r;
    check("t6_spins_initial", b_spins, 4'b0000);
    @(negedge clk);
    prev    = {$urandom, $urandom};
    b_mo    = prev;
    b_ns    = 8'd20;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    for (int k = 1; k <= total + 10; k++) begin
      int e = k - 1;
      if (e >= 1 && e <= total) begin
        s = (e - 1) / PERIOD;
        p = e - PERIOD * s;
        if (p == 1 + LAT) begin
          m_buf = prev;
        end else if (p >= LAT + 2) begin
          i = p - LAT - 2;
          h = shortint'(m_buf[16*i +: 16]);
          r = shortint'(m_lfsr);
          if (h > r)      m_spins[i] = 1'b1;
          else if (h < r) m_spins[i] = 1'b0;
          m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
      end
      check($sformatf("t6_spins_k%0d", k), b_spins, m_spins);
      if (b_done && done_k < 0) done_k = k;
      prev = {$urandom, $urandom};
      b_mo = prev;
      @(posedge clk); #1;
    end
    check("t6_done_cycle", done_k, total + 1);
    check("t6_sweep_count", b_sc, 8'd20);
  endtask

  initial begin
    rst_n   = 1'b0;
    a_start = 1'b0; b_start = 1'b0;
    a_ns    = 8'd0; b_ns    = 8'd0;
    a_mo    = '0;   b_mo    = '0;

    vecs[0] = '{64'hFFFB_0000_0007_FFFF, 8'd1,   4'b0110};
    vecs[1] = '{64'h0003_FFFE_0000_0000, 8'd3,   4'b1010};
    vecs[2] = '{64'h0001_0001_0001_0001, 8'd0,   4'b1010};
    vecs[3] = '{64'h8000_7FFF_FFFF_0001, 8'd2,   4'b0101};
    vecs[4] = '{64'h0000_0000_0000_0000, 8'd255, 4'b0101};

    repeat (3) @(posedge clk);
    #1;
    check("reset_spins_a", a_spins, 4'b0101);
    check("reset_spins_b", b_spins, 4'b0000);
    check("reset_busy", a_busy, 1'b0);
    check("reset_done", a_done, 1'b0);
    check("reset_ready", a_ready, 1'b0);
    check("reset_sweep_count", a_sc, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_vec(vecs[v], v);
      repeat (2) @(posedge clk);
    end
    seq_start_during_run();
    seq_async_reset();
    seq_stochastic();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
